usb_ep_arbiter: RTL and testbench

//  Round-robin arbiter sharing the protocol engine's single IN/OUT endpoint data port among
//  NUM_REQ endpoint requesters (CDC data, CDC notify, control, ...). Sits between the endpoint

---
 rtl/usb_ep_arbiter.sv | 145 ++++++++++++++
 tb/tb_usb_ep_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_arbiter.sv
// Round-robin arbiter sharing the USB protocol engine's single endpoint data port.
// Optional grant watchdog: define USB_ARB_TIMEOUT_EN to enable revoke-on-timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate whenever bus_busy is low
// GRANT   | one requester owns the port; held until it drops req (or timeout)
// RELEASE | single grant-free handoff cycle; arbitration runs here too
module usb_ep_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic               clk_48mhz,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               bus_busy,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout_evt
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   idx_nx;
  logic [IDX_W-1:0]   last_owner, last_nx;
  logic [IDX_W-1:0]   win, cand;
  logic               found;
  logic               expire;
  logic               tevt_nx;
  int                 sum;

`ifdef USB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]    wd, wd_nx;
  logic [NUM_REQ-1:0] mask, mask_nx;

  // A revoked requester stays out of arbitration until it lets go of req.
  assign eligible = req & ~mask;
  assign expire   = (state == GRANT) && (wd == '0) && !bus_busy;

  // Down-counter: loaded while not granting, so it starts full on GRANT entry.
  always_comb begin
    wd_nx   = wd;
    mask_nx = mask & req;
    if (state != GRANT)
      wd_nx = WD_W'(TIMEOUT_CYCLES - 1);
    else if (!bus_busy && (wd != '0))
      wd_nx = wd - WD_W'(1);
    if (tevt_nx)
      mask_nx[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_48mhz or posedge rst) begin
    if (rst) begin
      wd   <= '0;
      mask <= '0;
    end else begin
      wd   <= wd_nx;
      mask <= mask_nx;
    end
  end
`else
  assign eligible = req;
  // Watchdog compiled out; the parameter is kept so both builds share one interface.
  assign expire   = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Rotating priority: scan upward from the requester after last_owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    sum   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_owner) + k;
      if (sum >= NUM_REQ)
        sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    idx_nx   = grant_idx;
    last_nx  = last_owner;
    tevt_nx  = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        state_nx = IDLE;
        grant_nx = '0;
        idx_nx   = '0;
        if (found && !bus_busy) begin
          state_nx      = GRANT;
          grant_nx[win] = 1'b1;
          idx_nx        = win;
        end
      end
      GRANT: begin
        // A normal release on the expiry cycle takes precedence over the revoke.
        if ((!req[grant_idx] && !bus_busy) || expire) begin
          state_nx = RELEASE;
          grant_nx = '0;
          idx_nx   = '0;
          last_nx  = grant_idx;
          tevt_nx  = expire && req[grant_idx];
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_owner  <= IDX_W'(NUM_REQ - 1);
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      grant_valid <= |grant_nx;
      grant_idx   <= idx_nx;
      last_owner  <= last_nx;
      timeout_evt <= tevt_nx;
    end
  end

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Scoreboard bench for usb_ep_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Expected grant-change events are queued by the stimulus and popped by the monitor.
module tb_usb_ep_arbiter;

  logic       clk_48mhz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       bus_busy = 1'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       timeout_evt;

  usb_ep_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_48mhz  (clk_48mhz),
    .rst        (rst),
    .req        (req),
    .bus_busy   (bus_busy),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout_evt(timeout_evt)
  );

  typedef struct {
    int         en;
    logic [3:0] g;
    logic [1:0] idx;
    logic       tevt;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] prev_grant = 4'b0000;

  initial forever #5 clk_48mhz = ~clk_48mhz;

  always @(posedge clk_48mhz) cyc <= cyc + 1;

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic push(input int en, input logic [3:0] g, input logic [1:0] idx, input logic tevt);
    ev_t e;
    e.en = en; e.g = g; e.idx = idx; e.tevt = tevt;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req_v, cyc);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each grant change or timeout pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_48mhz);
      checks++;
      if (!$onehot0(grant) || (grant_valid !== |grant) ||
          (grant_valid ? (grant !== oh(int'(grant_idx))) : (grant_idx !== 2'd0))) begin
        failures++;
        $display("FAIL invariant grant=%b valid=%b idx=%0d (edge %0d)", grant, grant_valid, grant_idx, cyc);
      end
      if ((grant !== prev_grant) || (timeout_evt !== 1'b0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event grant=%b idx=%0d tevt=%b at edge %0d, none required",
                   grant, grant_idx, timeout_evt, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((e.en != cyc) || (e.g !== grant) || (e.idx !== grant_idx) || (e.tevt !== timeout_evt)) begin
            failures++;
            $display("FAIL grant_event actual edge=%0d grant=%b idx=%0d tevt=%b required edge=%0d grant=%b idx=%0d tevt=%b",
                     cyc, grant, grant_idx, timeout_evt, e.en, e.g, e.idx, e.tevt);
          end
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    int e0;
    // Reset state
    tick(3);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(grant_valid), 32'h0);
    check("rst_idx", 32'(grant_idx), 32'h0);
    check("rst_tevt", 32'(timeout_evt), 32'h0);

    // 1: all requesting, each owner drops 3 cycles after grant then re-raises
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(cyc + 1, oh(k % 4), 2'(k % 4), 1'b0);
      tick(3);
      req[k % 4] = 1'b0;
      push(cyc + 1, 4'b0000, 2'd0, 1'b0);
      tick(1);
      if (k < 4) req[k % 4] = 1'b1;
      else req = 4'b0000;
    end
    tick(2);

    // 2: single request, no preemption by req[0]
    req = 4'b0100;
    push(cyc + 1, 4'b0100, 2'd2, 1'b0);
    tick(1);
    req = 4'b0101;
    tick(3);
    check("no_preempt", 32'(grant), 32'h4);
    req = 4'b0001;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    push(cyc + 2, 4'b0001, 2'd0, 1'b0);
    tick(2);
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(2);

    // 3: owner drops req while bus_busy; then no grant while busy in IDLE
    req = 4'b0010;
    push(cyc + 1, 4'b0010, 2'd1, 1'b0);
    tick(1);
    bus_busy = 1'b1;
    req = 4'b0000;
    tick(3);
    check("busy_hold", 32'(grant), 32'h2);
    tick(2);
    bus_busy = 1'b0;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(1);
    bus_busy = 1'b1;
    req = 4'b0001;
    tick(4);
    check("busy_idle", 32'(grant_valid), 32'h0);
    bus_busy = 1'b0;
    push(cyc + 1, 4'b0001, 2'd0, 1'b0);
    tick(1);
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(2);

    // 4: reset mid-grant clears immediately; requester 0 first afterwards
    req = 4'b1000;
    push(cyc + 1, 4'b1000, 2'd3, 1'b0);
    tick(2);
    push(cyc, 4'b0000, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_valid", 32'(grant_valid), 32'h0);
    check("midrst_idx", 32'(grant_idx), 32'h0);
    tick(1);
    rst = 1'b0;
    req = 4'b1001;
    push(cyc + 1, 4'b0001, 2'd0, 1'b0);
    tick(1);
    req = 4'b1000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    push(cyc + 2, 4'b1000, 2'd3, 1'b0);
    tick(2);
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(2);

    // 5: sole requester holds req for 40 cycles
    e0 = cyc;
    req = 4'b0001;
    push(e0 + 1, 4'b0001, 2'd0, 1'b0);
`ifdef USB_ARB_TIMEOUT_EN
    push(e0 + 17, 4'b0000, 2'd0, 1'b1);
`endif
    tick(10);
    check("wd_early_hold", 32'(grant), 32'h1);
    tick(15);
`ifdef USB_ARB_TIMEOUT_EN
    check("wd_masked", 32'(grant_valid), 32'h0);
`else
    check("no_wd_hold", 32'(grant), 32'h1);
`endif
    tick(15);
    req = 4'b0000;
`ifndef USB_ARB_TIMEOUT_EN
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
`endif
    tick(1);
    req = 4'b0001;
    push(cyc + 1, 4'b0001, 2'd0, 1'b0);
    tick(1);
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(2);

    // 6: make requester 3 the last owner, then 0 and 1 both request
    req = 4'b1000;
    push(cyc + 1, 4'b1000, 2'd3, 1'b0);
    tick(1);
    req = 4'b0000;
    push(cyc + 1, 4'b0000, 2'd0, 1'b0);
    tick(3);
    e0 = cyc;
    req = 4'b0011;
    push(e0 + 1, 4'b0001, 2'd0, 1'b0);
`ifdef USB_ARB_TIMEOUT_EN
    push(e0 + 17, 4'b0000, 2'd0, 1'b1);
    push(e0 + 18, 4'b0010, 2'd1, 1'b0);
`endif
    tick(20);
    req = 4'b0000;
    push(e0 + 21, 4'b0000, 2'd0, 1'b0);
    tick(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached at edge %0d", cyc);
    $fatal(1);
  end

endmodule
